// File: rtl/bus_wait_gen.sv
// Wait-state generator feeding rdy1/aen1 of an 8284A from 8088 status and ISA I/O CH RDY.
// Optional WAIT_TIMEOUT_EN macro adds a forced release after TIMEOUT clocks in WAIT.
module bus_wait_gen #(
  parameter int IO_WAITS  = 1,
  parameter int MEM_WAITS = 0,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] s_n,
  input  logic       io_ch_rdy,
  input  logic       hlda,
  output logic       rdy1,
  output logic       aen1,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  generate
    if (IO_WAITS >= (2 ** CNT_W) || MEM_WAITS >= (2 ** CNT_W) || TIMEOUT < 1) begin : g_param_err
      $error("bus_wait_gen: wait counts must fit CNT_W and TIMEOUT must be positive");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       s_prev;
  logic             aen1_q;
  logic             start;
  logic             rel_ok;
  logic             force_rel;

  // A cycle begins only on a passive-to-active status edge; HALT never starts one.
  assign start  = (s_prev == 3'b111) && (s_n != 3'b111) && (s_n != 3'b011) && !hlda;
  assign rel_ok = (cnt <= CNT_W'(1)) && io_ch_rdy;

`ifdef WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          timeout_q;

  assign force_rel = (timer == TW'(TIMEOUT - 1));

  // Timer sits at zero outside WAIT, so it is cleared on every WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer     <= (state == WAIT) ? timer + TW'(1) : '0;
      timeout_q <= (state == WAIT) && force_rel && !rel_ok;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = T1;
          cnt_nxt   = s_n[2] ? CNT_W'(MEM_WAITS) : CNT_W'(IO_WAITS);
        end
      end
      T1: state_nxt = T2;
      T2: begin
        if (cnt == '0 && io_ch_rdy) state_nxt = DONE;
        else                        state_nxt = WAIT;
      end
      WAIT: begin
        cnt_nxt = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        if (rel_ok || force_rel) state_nxt = DONE;
      end
      DONE: begin
        if (s_n == 3'b111) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      s_prev <= 3'b111;
      aen1_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      s_prev <= s_n;
      aen1_q <= hlda;
    end
  end

  // rdy1 decodes state flops only, so no input reaches it combinationally.
  assign rdy1      = (state != WAIT);
  assign busy      = (state != IDLE);
  assign aen1      = aen1_q;
  assign dbg_state = state;

endmodule
